regdump_reader: RTL and testbench



---
 rtl/regdump_pkg.sv | 25 ++
 rtl/regdump_byte_tx.sv | 28 ++
 rtl/regdump_reader.sv | 157 +++++++++++++++
 tb/tb_regdump_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared types and helpers for the register-file dump reader.
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_TRAIL = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    localparam logic [7:0] REGDUMP_HEADER_DEFAULT = 8'hA5;

    function automatic logic [7:0] sel_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic        msb_first
    );
        logic [1:0] lane;
        lane = msb_first ? (2'd3 - idx) : idx;
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/regdump_byte_tx.sv
// Output byte register: holds tx_valid/tx_data until the transmitter takes it.
module regdump_byte_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       accepted
);

    assign accepted = tx_valid && tx_ready;

    // A load on the accept cycle keeps the stream back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= load_data;
        end else if (accepted) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regdump_reader.sv
// Walks the register file and frames it as header, data bytes, XOR trailer.
module regdump_reader
    import regdump_pkg::*;
#(
    parameter int         FIRST_REG = 0,
    parameter int         LAST_REG  = 31,
    parameter logic [7:0] HEADER    = REGDUMP_HEADER_DEFAULT,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    state_t      state;
    state_t      state_nx;
    logic [31:0] word_reg;
    logic [1:0]  byte_cnt;
    logic [7:0]  checksum;
    logic        abort_q;
    logic        hs;
    logic        honour;
    logic        start_ok;
    logic        last_byte;
    logic        last_reg;
    logic        load;
    logic [7:0]  load_data;

    regdump_byte_tx u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .accepted  (hs)
    );

    assign start_ok  = (state == ST_IDLE) && start && !abort;
    assign last_byte = (byte_cnt == 2'd3);
    assign last_reg  = (rf_addr == LAST_A);

    // Abort only lands on a byte boundary so no half-sent byte is dropped.
    assign honour = (abort || abort_q)
                  && (state inside {ST_HDR, ST_LOAD, ST_SEND, ST_TRAIL})
                  && (hs || !tx_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start_ok) state_nx = ST_HDR;
            ST_HDR: begin
                if (honour)  state_nx = ST_IDLE;
                else if (hs) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (honour) state_nx = ST_IDLE;
                else        state_nx = ST_SEND;
            end
            ST_SEND: begin
                if (honour)
                    state_nx = ST_IDLE;
                else if (hs && last_byte)
                    state_nx = last_reg ? ST_TRAIL : ST_LOAD;
            end
            ST_TRAIL: begin
                if (honour)  state_nx = ST_IDLE;
                else if (hs) state_nx = ST_FIN;
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_data = 8'h00;
        busy      = (state != ST_IDLE);
        done      = (state == ST_FIN);
        unique case (state)
            ST_IDLE: begin
                load      = start_ok;
                load_data = HEADER;
            end
            ST_LOAD: begin
                load      = !honour;
                load_data = sel_byte(rf_data, 2'd0, MSB_FIRST);
            end
            ST_SEND: begin
                load = hs && !honour && (!last_byte || last_reg);
                if (last_byte)
                    load_data = checksum ^ tx_data;
                else
                    load_data = sel_byte(word_reg, byte_cnt + 2'd1, MSB_FIRST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_addr  <= 5'd0;
            checksum <= 8'h00;
            word_reg <= 32'd0;
            byte_cnt <= 2'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        rf_addr  <= FIRST_A;
                        checksum <= 8'h00;
                    end
                end
                ST_LOAD: begin
                    word_reg <= rf_data;
                    byte_cnt <= 2'd0;
                end
                ST_SEND: begin
                    if (hs) begin
                        checksum <= checksum ^ tx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte && !last_reg && !honour)
                            rf_addr <= rf_addr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            abort_q <= 1'b0;
        else if (state_nx == ST_IDLE)
            abort_q <= 1'b0;
        else if (abort && state != ST_IDLE)
            abort_q <= 1'b1;
    end

endmodule

// File: tb/tb_regdump_reader.sv
// Self-checking bench: frame model from register contents, stalls, abort, reset.
module tb_regdump_reader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [8*12-1:0] name;
        int              fill;
        bit              stall;
        int              mid_start;
        int              exp_busy;
        int              exp_trail;
        bit              same_prev;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, abort_a, tx_ready_a;
    logic        busy_a, done_a, tx_valid_a;
    logic [4:0]  rf_addr_a;
    logic [31:0] rf_data_a;
    logic [7:0]  tx_data_a;
    logic        start_b, abort_b, tx_ready_b;
    logic        busy_b, done_b, tx_valid_b;
    logic [4:0]  rf_addr_b;
    logic [31:0] rf_data_b;
    logic [7:0]  tx_data_b;

    logic [31:0] rf [32];
    byte_q_t     cap_a, cap_b, exp_q, prev_cap;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt_a, busy_cyc_a, done_cyc_a, fall_cyc_a, hold_viol;
    int          done_cnt_b;
    bit          rdy_mode;
    logic        rdy_val;
    logic        hold_a = 1'b0;
    logic [7:0]  held_a;
    logic        busy_prev = 1'b0;

    always #5 clk = ~clk;

    assign rf_data_a = (rf_addr_a == 5'd0) ? 32'd0 : rf[rf_addr_a];
    assign rf_data_b = (rf_addr_b == 5'd0) ? 32'd0 : rf[rf_addr_b];

    regdump_reader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .rf_addr(rf_addr_a),
        .rf_data(rf_data_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a)
    );

    regdump_reader #(.FIRST_REG(5), .LAST_REG(5), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .rf_addr(rf_addr_b),
        .rf_data(rf_data_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b)
    );

    // Ready is chosen first; a byte with valid&&ready here is taken at the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (reset) hold_a = 1'b0;
        else if (hold_a && (!tx_valid_a || tx_data_a !== held_a)) hold_viol++;
        tx_ready_a = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
        if (!reset && tx_valid_a && tx_ready_a) cap_a.push_back(tx_data_a);
        hold_a = !reset && tx_valid_a && !tx_ready_a;
        held_a = tx_data_a;
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (busy_a) busy_cyc_a++;
        if (busy_prev && !busy_a) fall_cyc_a = cyc;
        busy_prev = busy_a;
        if (!reset && tx_valid_b && tx_ready_b) cap_b.push_back(tx_data_b);
        if (done_b) done_cnt_b++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic int count_diff(input byte_q_t a, input byte_q_t b);
        int n = 0;
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic build_exp(input int first, input int last, input bit msb);
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  ck;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        ck = 8'h00;
        for (int r = first; r <= last; r++) begin
            w = (r == 0) ? 32'd0 : rf[r];
            for (int k = 0; k < 4; k++) begin
                b = msb ? 8'(w >> (8 * (3 - k))) : 8'(w >> (8 * k));
                exp_q.push_back(b);
                ck ^= b;
            end
        end
        exp_q.push_back(ck);
    endtask

    task automatic clear_a;
        cap_a.delete();
        done_cnt_a = 0;
        busy_cyc_a = 0;
        done_cyc_a = -100;
        fall_cyc_a = 0;
        hold_viol  = 0;
    endtask

    task automatic dump_a(input int mid_start);
        int n;
        clear_a();
        @(negedge clk); #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        n = 0;
        while (busy_a && n < 3000) begin
            @(negedge clk); #1;
            n++;
            start_a = (n == mid_start);
        end
        start_a = 1'b0;
        chk("dump_timeout", n < 3000, 1'b1);
    endtask

    task automatic wait_cap(input int want);
        int k = 0;
        while (cap_a.size() < want && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_cap", cap_a.size() >= want, 1'b1);
    endtask

    vec_t        vecs[4];
    logic [7:0]  exp_b [6];
    int          n;
    int          k;
    logic [7:0]  held;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"spec_preset", 0, 1'b0, 0,  163, 'h44, 1'b0};
        vecs[1] = '{"rand_nostall", 1, 1'b0, 0, 163, -1, 1'b0};
        vecs[2] = '{"rand_stall", 2, 1'b1, 0,   -1,  -1, 1'b1};
        vecs[3] = '{"restart_mid", 1, 1'b0, 40, 163, -1, 1'b0};
        exp_b = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};

        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; tx_ready_b = 1'b1;
        rdy_mode = 1'b0; rdy_val = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_valid", tx_valid_a, 1'b0);
        chk("rst_data", tx_data_a, 8'h00);
        chk("rst_addr", rf_addr_a, 5'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].fill == 0) begin
                for (int i = 0; i < 32; i++) rf[i] = 32'd0;
                rf[1] = 32'h11223344;
            end else if (vecs[v].fill == 1) begin
                for (int i = 1; i < 32; i++) rf[i] = $urandom;
            end
            rdy_mode = vecs[v].stall;
            rdy_val  = 1'b1;
            build_exp(0, 31, 1'b1);
            dump_a(vecs[v].mid_start);
            repeat (6) @(negedge clk);
            #1;
            chk($sformatf("%s_len", vecs[v].name), cap_a.size(), 130);
            chk($sformatf("%s_bytes", vecs[v].name), count_diff(cap_a, exp_q), 0);
            chk($sformatf("%s_done", vecs[v].name), done_cnt_a, 1);
            chk($sformatf("%s_hold", vecs[v].name), hold_viol, 0);
            chk($sformatf("%s_idle", vecs[v].name), busy_a, 1'b0);
            chk($sformatf("%s_fall", vecs[v].name), fall_cyc_a - done_cyc_a, 1);
            if (vecs[v].exp_busy > 0)
                chk($sformatf("%s_cycles", vecs[v].name), busy_cyc_a, vecs[v].exp_busy);
            if (vecs[v].exp_trail >= 0 && cap_a.size() > 0)
                chk($sformatf("%s_trailer", vecs[v].name), cap_a[$], vecs[v].exp_trail);
            if (vecs[v].same_prev)
                chk($sformatf("%s_vs_prev", vecs[v].name), count_diff(cap_a, prev_cap), 0);
            prev_cap = cap_a;
        end

        // abort while a SEND byte is stalled
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        build_exp(0, 31, 1'b1);
        rdy_mode = 1'b0; rdy_val = 1'b1;
        clear_a();
        @(negedge clk); #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        wait_cap(3);
        rdy_val = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n = cap_a.size();
        held = tx_data_a;
        chk("abort_stalled_valid", tx_valid_a, 1'b1);
        abort_a = 1'b1;
        @(negedge clk); #1 abort_a = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("abort_hold_valid", tx_valid_a, 1'b1);
        chk("abort_hold_data", tx_data_a, held);
        chk("abort_hold_busy", busy_a, 1'b1);
        chk("abort_hold_cnt", cap_a.size(), n);
        rdy_val = 1'b1;
        k = 0;
        while (busy_a && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (5) @(negedge clk);
        #1;
        chk("abort_idle", busy_a, 1'b0);
        chk("abort_cnt", cap_a.size(), n + 1);
        chk("abort_prefix", count_diff(cap_a, exp_q), 0);
        chk("abort_no_done", done_cnt_a, 0);
        chk("abort_valid_low", tx_valid_a, 1'b0);
        chk("abort_hold_rule", hold_viol, 0);
        dump_a(0);
        repeat (3) @(negedge clk);
        #1;
        chk("post_abort_len", cap_a.size(), 130);
        chk("post_abort_bytes", count_diff(cap_a, exp_q), 0);
        chk("post_abort_done", done_cnt_a, 1);

        // asynchronous reset mid-SEND
        rdy_mode = 1'b1;
        clear_a();
        @(negedge clk); #1 start_a = 1'b1;
        @(negedge clk); #1 start_a = 1'b0;
        wait_cap(10);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", tx_valid_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_addr", rf_addr_a, 5'd0);
        chk("arst_data", tx_data_a, 8'h00);
        @(negedge clk); #1 reset = 1'b0;
        rdy_mode = 1'b0; rdy_val = 1'b1;
        n = cap_a.size();
        repeat (20) @(negedge clk);
        #1;
        chk("arst_silent", cap_a.size(), n);
        chk("arst_stay_idle", busy_a, 1'b0);
        chk("arst_no_done", done_cnt_a, 0);
        dump_a(0);
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_len", cap_a.size(), 130);
        chk("post_rst_bytes", count_diff(cap_a, exp_q), 0);

        // LSB-first single-register instance
        rf[5] = 32'hDEADBEEF;
        build_exp(5, 5, 1'b0);
        cap_b.delete();
        done_cnt_b = 0;
        @(negedge clk); #1 start_b = 1'b1;
        @(negedge clk); #1 start_b = 1'b0;
        k = 0;
        while (busy_b && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("lsb_len", cap_b.size(), 6);
        chk("lsb_model", count_diff(cap_b, exp_q), 0);
        chk("lsb_done", done_cnt_b, 1);
        for (int i = 0; i < 6 && i < cap_b.size(); i++)
            chk($sformatf("lsb_byte%0d", i), cap_b[i], exp_b[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
